fp16_mem_add_engine: RTL and testbench
======================================

Name: fp16_mem_add_engine

Overview:
- Multi-cycle half-precision (1/5/10, bias 15) adder engine that sits directly upstream of data memory's result slots.
- On a start handshake it reads two operands from data memory, then aligns, adds, normalizes and packs them with truncation (no rounding).
- It writes the 16-bit result back to memory and raises done.
- It serves as the hardware golden model in float-add program benches, where its memory image is compared against the processor's.

Parameters:
- AW, 8, data-memory address width.
- BASE_ADDR, 128, operand 1 MSB/LSB at BASE/BASE+1, operand 2 at BASE+2/BASE+3, result MSB/LSB at BASE+4/BASE+5.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  level request; high = hold/abort, high-to-low transition launches one operation
- done  out  1  high from completion until start next rises or reset
- err  out  1  one-cycle pulse in DONE entry cycle when operand signs differ
- mem_addr  out  AW  byte address to data memory
- mem_rd_data  in  8  read data, registered memory, valid one cycle after mem_addr
- mem_wr_en  out  1  byte write strobe
- mem_wr_data  out  8  write byte

Behaviour:
- Reset: done=0, err=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, state=IDLE, operand/working registers cleared. Reset mid-operation aborts with no further writes.
- start_q registers start each cycle. Launch occurs in IDLE when start_q=1 and start=0. start=1 in any state forces IDLE next cycle, clears done, and suppresses writes.
- FSM, one cycle each:
  - IDLE
  - LD0 (addr BASE)
  - LD1 (BASE+1, capture op1 MSB)
  - LD2 (BASE+2, capture op1 LSB)
  - LD3 (BASE+3, capture op2 MSB)
  - LDW (capture op2 LSB)
  - ALIGN
  - ADD
  - NORM
  - WRH (addr BASE+4, wr_en, result[15:8])
  - WRL (BASE+5, result[7:0])
  - DONE: holds until start=1.
- Latency: done visible exactly 10 clocks after the edge at which start is first sampled low in IDLE. mem_wr_en is high only in WRH and WRL.
- Unpack: mant = {|exp, frac} (11 b). Exponent 0 carries no denormal adjustment.
- Align: the larger {exp,frac} magnitude is the big operand; tie selects op1. Shift small mant right by d = exp_big - exp_small, discarding bits shifted out. d >= 11 gives 0.
- Add: 12-bit sum of mantissas, same signs only.
- Normalize:
  - If sum[11]=1: sum >>= 1 (truncate), exp+1.
  - If exp_big=0 and sum[10]=1: result exp=1.
  - Otherwise exp=exp_big.
- Overflow: normalized exp = 31 (or any input exp = 31) gives {sign,5'h1F,10'h0}.
- Sign mismatch: subtraction is unsupported. Result = big operand unchanged, err pulses. Writes still occur.
- Zero + zero gives 0x0000. Zero + x gives x.
- Result sign = op1 sign (equal to op2 sign on the valid path).

Decomposition:
- Shared package fp16_pkg:
  - fp16_t packed struct {sign, exp[4:0], frac[9:0]}
  - state enum
  - constants BIAS=15, EXP_MAX=5'h1F, MANT_W=11
- One sub-module fp16_align_shift: combinational magnitude compare plus right barrel shift. Outputs big mant, shifted small mant, exp_big.

Test Plan:
- 0x1A04 + 0x1A04 -> mem[132]=0x1E, mem[133]=0x04, done 10 cycles after start falls, err=0.
- 0x4A10 + 0x4204 (d=2) -> result 0x4B91. mem_wr_en high for exactly 2 cycles at addrs 132,133.
- 0x6A0F + 0x5200 (d=6) -> 0x6A27. 0x7800 + 0x0400 (d=29) -> 0x7800 unchanged.
- 0x7A04 + 0x7A04 -> saturate to 0x7C00. 0x0000 + 0x0000 -> 0x0000.
- 0x4A10 + 0xC204 -> result 0x4A10, err high exactly 1 cycle coincident with done rising.
- Raise start during ADD, or assert reset during LD2 -> no writes to 132/133, done stays 0. Next start fall runs 0x1A04+0x1A04 -> 0x1E04 with nominal latency.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision memory adder engine.
// The state enum and operand struct are used by the top and the align stage.
package fp16_pkg;

  localparam int         BIAS    = 15;
  localparam logic [4:0] EXP_MAX = 5'h1F;
  localparam int         MANT_W  = 11;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_LD2, S_LD3, S_LDW,
    S_ALIGN, S_ADD, S_NORM, S_WRH, S_WRL, S_DONE
  } state_t;

  // Hidden bit is simply |exp; exponent 0 gets no denormal adjustment.
  function automatic logic [MANT_W-1:0] unpackMant(input fp16_t v);
    return {|v.exp, v.frac};
  endfunction

endpackage

// File: rtl/fp16_align_shift.sv
// Picks the larger-magnitude operand (ties go to operand 1) and right-shifts
// the smaller mantissa by the exponent difference, dropping shifted-out bits.
module fp16_align_shift
  import fp16_pkg::*;
(
  input  fp16_t             i_a,
  input  fp16_t             i_b,
  output fp16_t             o_big,
  output logic [MANT_W-1:0] o_bigMant,
  output logic [MANT_W-1:0] o_smallMant,
  output logic [4:0]        o_expBig
);

  fp16_t      w_small;
  logic [4:0] w_shift;

  always_comb begin
    if ({i_b.exp, i_b.frac} > {i_a.exp, i_a.frac}) begin
      o_big   = i_b;
      w_small = i_a;
    end else begin
      o_big   = i_a;
      w_small = i_b;
    end
    o_expBig  = o_big.exp;
    o_bigMant = unpackMant(o_big);
    w_shift   = o_big.exp - w_small.exp;
    if (w_shift >= 5'd11)
      o_smallMant = '0;
    else
      o_smallMant = unpackMant(w_small) >> w_shift;
  end

endmodule

// File: rtl/fp16_mem_add_engine.sv
// Multi-cycle fp16 adder: loads two operands from data memory, adds them with
// truncation, writes the result back, then holds done until start rises.
module fp16_mem_add_engine
  import fp16_pkg::*;
#(
  parameter int AW        = 8,
  parameter int BASE_ADDR = 128
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  state_t             r_state, w_stateNext;
  logic               r_startQ;
  logic [15:0]        r_op1, r_op2;
  fp16_t              r_big;
  logic [MANT_W-1:0]  r_bigMant, r_smallMant;
  logic [4:0]         r_expBig;
  logic [11:0]        r_sum;
  logic [15:0]        r_result;
  logic               r_done, r_err;

  fp16_t              w_op1, w_op2, w_big;
  logic [MANT_W-1:0]  w_bigMant, w_smallMant;
  logic [4:0]         w_expBig;
  logic               w_signDiff;
  logic [5:0]         w_expN;
  logic [9:0]         w_fracN;
  logic [15:0]        w_result;

  assign w_op1      = fp16_t'(r_op1);
  assign w_op2      = fp16_t'(r_op2);
  assign w_signDiff = w_op1.sign ^ w_op2.sign;

  fp16_align_shift u_align (
    .i_a         (w_op1),
    .i_b         (w_op2),
    .o_big       (w_big),
    .o_bigMant   (w_bigMant),
    .o_smallMant (w_smallMant),
    .o_expBig    (w_expBig)
  );

  // A high start aborts from any state; a falling start launches from IDLE.
  always_comb begin
    w_stateNext = r_state;
    if (start) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_startQ) w_stateNext = S_LD0;
        S_LD0:   w_stateNext = S_LD1;
        S_LD1:   w_stateNext = S_LD2;
        S_LD2:   w_stateNext = S_LD3;
        S_LD3:   w_stateNext = S_LDW;
        S_LDW:   w_stateNext = S_ALIGN;
        S_ALIGN: w_stateNext = S_ADD;
        S_ADD:   w_stateNext = S_NORM;
        S_NORM:  w_stateNext = S_WRH;
        S_WRH:   w_stateNext = S_WRL;
        S_WRL:   w_stateNext = S_DONE;
        S_DONE:  w_stateNext = S_DONE;
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_startQ <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_startQ <= start;
      r_done   <= (w_stateNext == S_DONE);
      r_err    <= (r_state == S_WRL) && (w_stateNext == S_DONE) && w_signDiff;
    end
  end

  // Read data trails the address by one cycle, so each capture uses the
  // address issued in the previous state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_big       <= '0;
      r_bigMant   <= '0;
      r_smallMant <= '0;
      r_expBig    <= '0;
      r_sum       <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_LD1:   r_op1[15:8] <= mem_rd_data;
        S_LD2:   r_op1[7:0]  <= mem_rd_data;
        S_LD3:   r_op2[15:8] <= mem_rd_data;
        S_LDW:   r_op2[7:0]  <= mem_rd_data;
        S_ALIGN: begin
          r_big       <= w_big;
          r_bigMant   <= w_bigMant;
          r_smallMant <= w_smallMant;
          r_expBig    <= w_expBig;
        end
        S_ADD:   r_sum    <= {1'b0, r_bigMant} + {1'b0, r_smallMant};
        S_NORM:  r_result <= w_result;
        default: ;
      endcase
    end
  end

  // Normalize with truncation; mismatched signs pass the big operand through.
  always_comb begin
    w_expN  = {1'b0, r_expBig};
    w_fracN = r_sum[9:0];
    if (r_sum[11]) begin
      w_expN  = {1'b0, r_expBig} + 6'd1;
      w_fracN = r_sum[10:1];
    end else if ((r_expBig == 5'd0) && r_sum[10]) begin
      w_expN = 6'd1;
    end
    if (w_signDiff)
      w_result = r_big;
    else if ((w_expN >= {1'b0, EXP_MAX}) || (w_op1.exp == EXP_MAX) || (w_op2.exp == EXP_MAX))
      w_result = {w_op1.sign, EXP_MAX, 10'h000};
    else
      w_result = {w_op1.sign, w_expN[4:0], w_fracN};
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (r_state)
      S_LD0: mem_addr = AW'(BASE_ADDR);
      S_LD1: mem_addr = AW'(BASE_ADDR + 1);
      S_LD2: mem_addr = AW'(BASE_ADDR + 2);
      S_LD3: mem_addr = AW'(BASE_ADDR + 3);
      S_WRH: begin
        mem_addr    = AW'(BASE_ADDR + 4);
        mem_wr_en   = !start && !reset;
        mem_wr_data = r_result[15:8];
      end
      S_WRL: begin
        mem_addr    = AW'(BASE_ADDR + 5);
        mem_wr_en   = !start && !reset;
        mem_wr_data = r_result[7:0];
      end
      default: ;
    endcase
  end

  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_fp16_mem_add_engine.sv
// Scoreboard bench for fp16_mem_add_engine: stimulus pushes reference results,
// a negedge monitor checks memory image, err pulse and latency on done.
module tb_fp16_mem_add_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done, err;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0]  mem [256];
  logic        loadEn;
  logic [15:0] loadOp1, loadOp2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] result;
    logic        err;
    int          launchCyc;
  } exp_t;

  exp_t expQ[$];
  int   wrAddrQ[$];

  fp16_mem_add_engine #(.AW(8), .BASE_ADDR(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  // Registered data memory with a bench-side preload port for operands.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (loadEn) begin
      mem[128] <= loadOp1[15:8];
      mem[129] <= loadOp1[7:0];
      mem[130] <= loadOp2[15:8];
      mem[131] <= loadOp2[7:0];
      mem[132] <= 8'hA5;
      mem[133] <= 8'h5A;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference: value-level fp16 add with truncation, from the arithmetic rules.
  function automatic logic [16:0] refAdd(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, eBig, mBig, mSmall, d, sum, e;
    logic [15:0] res;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = int'(a[9:0]) + ((ea != 0) ? 1024 : 0);
    mb = int'(b[9:0]) + ((eb != 0) ? 1024 : 0);
    if (a[15] != b[15]) begin
      res = (b[14:0] > a[14:0]) ? b : a;
      return {1'b1, res};
    end
    if (ea == 31 || eb == 31) return {1'b0, a[15], 5'h1F, 10'h000};
    if (b[14:0] > a[14:0]) begin
      eBig = eb; mBig = mb; mSmall = ma; d = eb - ea;
    end else begin
      eBig = ea; mBig = ma; mSmall = mb; d = ea - eb;
    end
    mSmall = (d >= 11) ? 0 : (mSmall / (1 << d));
    sum = mBig + mSmall;
    e = eBig;
    if (sum >= 2048) begin
      sum = sum / 2;
      e = e + 1;
    end else if (eBig == 0 && sum >= 1024) begin
      e = 1;
    end
    if (e >= 31) return {1'b0, a[15], 5'h1F, 10'h000};
    res = {a[15], 5'(e), 10'(sum % 1024)};
    return {1'b0, res};
  endfunction

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start   = 1'b1;
    loadEn  = 1'b1;
    loadOp1 = a;
    loadOp2 = b;
    @(negedge clk);
    loadEn = 1'b0;
    @(negedge clk);
  endtask

  // Launches one add, records the expectation and waits (bounded) for done.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] r;
    bit seen;
    preload(a, b);
    r = refAdd(a, b);
    e.result    = r[15:0];
    e.err       = r[16];
    e.launchCyc = cyc + 1;
    expQ.push_back(e);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checkOutput("done_timeout", 32'(done), 32'd1);
      void'(expQ.pop_back());
    end
    waitCycles(2);
    start = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every done rise must match the oldest expectation.
  logic doneQ = 1'b0;
  bit   errNext = 0;
  always @(negedge clk) begin
    exp_t e;
    if (mem_wr_en) wrAddrQ.push_back(int'(mem_addr));
    if (errNext) begin
      checkOutput("err_width", 32'(err), 32'd0);
      errNext = 0;
    end
    if (done && !doneQ && !reset) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("latency", 32'(cyc - e.launchCyc), 32'd10);
        checkOutput("err_pulse", 32'(err), 32'(e.err));
        checkOutput("result", {16'h0, mem[132], mem[133]}, {16'h0, e.result});
        checkOutput("write_count", 32'(wrAddrQ.size()), 32'd2);
        if (wrAddrQ.size() == 2) begin
          checkOutput("write_addr_hi", 32'(wrAddrQ[0]), 32'd132);
          checkOutput("write_addr_lo", 32'(wrAddrQ[1]), 32'd133);
        end
        errNext = 1;
      end
      wrAddrQ.delete();
    end else if (err) begin
      checkOutput("err_spurious", 32'(err), 32'd0);
    end
    doneQ <= done;
  end

  task automatic checkAborted(input string name);
    bit sawDone;
    sawDone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput({name, "_done"}, 32'(sawDone), 32'd0);
    checkOutput({name, "_writes"}, 32'(wrAddrQ.size()), 32'd0);
    checkOutput({name, "_mem"}, {16'h0, mem[132], mem[133]}, 32'h0000A55A);
    wrAddrQ.delete();
  endtask

  initial begin
    logic [15:0] a, b;
    int launch;
    reset  = 1'b1;
    start  = 1'b1;
    loadEn = 1'b0;
    loadOp1 = '0;
    loadOp2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    waitCycles(3);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("reset_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(mem_wr_data), 32'd0);
    reset = 1'b0;
    waitCycles(2);

    applyStimulus(16'h1A04, 16'h1A04);
    applyStimulus(16'h4A10, 16'h4204);
    applyStimulus(16'h6A0F, 16'h5200);
    applyStimulus(16'h7800, 16'h0400);
    applyStimulus(16'h7A04, 16'h7A04);
    applyStimulus(16'h0000, 16'h0000);
    applyStimulus(16'h4A10, 16'hC204);
    applyStimulus(16'h0000, 16'h3C00);
    applyStimulus(16'h0200, 16'h0300);
    applyStimulus(16'hBC00, 16'hBC00);

    // Abort by raising start while the engine sits in ADD.
    preload(16'h1A04, 16'h1A04);
    launch = cyc + 1;
    start = 1'b0;
    while (cyc != launch + 6) @(negedge clk);
    start = 1'b1;
    checkAborted("abort_start");
    applyStimulus(16'h1A04, 16'h1A04);

    // Abort by synchronous reset while in LD2.
    preload(16'h1A04, 16'h1A04);
    launch = cyc + 1;
    start = 1'b0;
    while (cyc != launch + 2) @(negedge clk);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    checkAborted("abort_reset");
    applyStimulus(16'h1A04, 16'h1A04);

    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(3) != 0) b[15] = a[15];
      if (a[15] != b[15] && (a[14:10] == 5'h1F || b[14:10] == 5'h1F)) b[15] = a[15];
      applyStimulus(a, b);
    end

    waitCycles(3);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
